read_superpixel: RTL and testbench

//  Read-back counterpart of the superpixel writer. Takes a superpixel coordinate, reads its

---
 rtl/read_superpixel.sv | 183 ++++++++++++++++++
 tb/tb_read_superpixel.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/read_superpixel.sv
// rtl/read_superpixel.sv - superpixel colour read-back from the VGA frame RAM read port
//
// Takes a superpixel coordinate, reads its pixel block from the frame RAM and
// returns the colour ID of the top-left pixel, whether the block is uniform,
// and whether the coordinate was out of range.
//
// Optional feature macro: SPIXEL_UNIFORM_CHECK_EN
//   defined   : every pixel of the block is read in raster order and compared
//               against the first word to produce ouniform.
//   undefined : only the top-left pixel is read; ouniform=1 on any non-error result.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   x, y              superpixel coordinate, sampled when ireq_vld && ordy
//   ireq_vld / ordy   request handshake (ordy high only when idle)
//   odata             colour ID of the block's top-left pixel
//   ouniform          1 = every scanned pixel equals odata
//   oerr              1 = coordinate out of range
//   odone             one-cycle pulse, result outputs valid from here on
//   oaddr / orden     RAM read address / enable (oaddr is 0 while orden=0)
//   irdata            RAM read data, RD_LATENCY cycles after orden
module read_superpixel #(
   parameter int SPIXEL_X_WIDTH = 6,
   parameter int SPIXEL_Y_WIDTH = 6,
   parameter int SPIXEL_X_MAX   = 63,
   parameter int SPIXEL_Y_MAX   = 47,
   parameter int PIXEL_X_WIDTH  = 10,
   parameter int PIXEL_Y_WIDTH  = 9,
   parameter int PIXEL_X_MAX    = 639,
   parameter int PIXEL_Y_MAX    = 479,
   parameter int VGA_ADDR_WIDTH = 19,
   parameter int COLOR_ID_WIDTH = 8,
   parameter int RD_LATENCY     = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SPIXEL_X_WIDTH-1:0] x,
   input  logic [SPIXEL_Y_WIDTH-1:0] y,
   input  logic                      ireq_vld,
   output logic                      ordy,
   output logic [COLOR_ID_WIDTH-1:0] odata,
   output logic                      ouniform,
   output logic                      oerr,
   output logic                      odone,
   output logic [VGA_ADDR_WIDTH-1:0] oaddr,
   output logic                      orden,
   input  logic [COLOR_ID_WIDTH-1:0] irdata
);

   localparam int PITCH = PIXEL_X_MAX + 1;
   localparam int BLK_W = PITCH / (SPIXEL_X_MAX + 1);
   localparam int BLK_H = (PIXEL_Y_MAX + 1) / (SPIXEL_Y_MAX + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [RD_LATENCY-1:0] PIPE_TOP = RD_LATENCY'(1) << (RD_LATENCY - 1);
   localparam logic [VGA_ADDR_WIDTH-1:0] PITCH_A = VGA_ADDR_WIDTH'(PITCH);

   logic [1:0]                state;
   logic [VGA_ADDR_WIDTH-1:0] addr_r;
   logic [RD_LATENCY-1:0]     vpipe;      // one bit per read in flight
   logic                      first_r;    // next returned word is the top-left pixel
   logic [COLOR_ID_WIDTH-1:0] data_r;
   logic                      uni_r;
   logic [COLOR_ID_WIDTH-1:0] data_nx;
   logic                      uni_nx;
   logic                      out_of_range;
   logic [VGA_ADDR_WIDTH-1:0] start_addr;
   logic                      last_rd;
   logic                      last_in;

   // One extra bit so the range compare is never constant when *_MAX fills the field.
   assign out_of_range = ({1'b0, x} > (SPIXEL_X_WIDTH+1)'(SPIXEL_X_MAX)) ||
                         ({1'b0, y} > (SPIXEL_Y_WIDTH+1)'(SPIXEL_Y_MAX));
   // Computed once per request; the scan itself only adds.
   assign start_addr = VGA_ADDR_WIDTH'(int'(y) * BLK_H * PITCH + int'(x) * BLK_W);

   assign ordy  = (state == S_IDLE);
   assign orden = (state == S_ISSUE);
   assign odone = (state == S_DONE);
   assign oaddr = orden ? addr_r : '0;

   // The last word is in when the top pipe stage is the only one still occupied;
   // reads are only issued in ISSUE, so this test is only used from DRAIN.
   assign last_in = vpipe[RD_LATENCY-1] && ((vpipe & ~PIPE_TOP) == '0);

   // Value of the result registers after absorbing the word on irdata this cycle.
   assign data_nx = first_r ? irdata : data_r;

`ifdef SPIXEL_UNIFORM_CHECK_EN
   localparam int CW = $clog2(BLK_W + 1);
   localparam int RW = $clog2(BLK_H + 1);

   logic [VGA_ADDR_WIDTH-1:0] row_base;   // address of the current row's first pixel
   logic [CW-1:0]             col_cnt;
   logic [RW-1:0]             row_cnt;

   assign last_rd = (col_cnt == CW'(BLK_W - 1)) && (row_cnt == RW'(BLK_H - 1));
   assign uni_nx  = first_r ? 1'b1 : (uni_r && (irdata == data_r));
`else
   assign last_rd = 1'b1;
   assign uni_nx  = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         addr_r   <= '0;
         vpipe    <= '0;
         first_r  <= 1'b0;
         data_r   <= '0;
         uni_r    <= 1'b0;
         odata    <= '0;
         ouniform <= 1'b0;
         oerr     <= 1'b0;
`ifdef SPIXEL_UNIFORM_CHECK_EN
         row_base <= '0;
         col_cnt  <= '0;
         row_cnt  <= '0;
`endif
      end else begin
         vpipe <= (vpipe << 1) | RD_LATENCY'(orden);

         if (vpipe[RD_LATENCY-1]) begin
            data_r  <= data_nx;
            uni_r   <= uni_nx;
            first_r <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (ireq_vld) begin
                  odata    <= '0;
                  ouniform <= 1'b0;
                  oerr     <= 1'b0;
                  if (out_of_range) begin
                     oerr  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     addr_r  <= start_addr;
                     first_r <= 1'b1;
                     uni_r   <= 1'b1;
`ifdef SPIXEL_UNIFORM_CHECK_EN
                     row_base <= start_addr;
                     col_cnt  <= '0;
                     row_cnt  <= '0;
`endif
                     state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (last_rd) begin
                  state <= S_DRAIN;
               end
`ifdef SPIXEL_UNIFORM_CHECK_EN
               else if (col_cnt == CW'(BLK_W - 1)) begin
                  col_cnt  <= '0;
                  row_cnt  <= row_cnt + RW'(1);
                  row_base <= row_base + PITCH_A;
                  addr_r   <= row_base + PITCH_A;
               end else begin
                  col_cnt <= col_cnt + CW'(1);
                  addr_r  <= addr_r + VGA_ADDR_WIDTH'(1);
               end
`endif
            end
            S_DRAIN: begin
               if (last_in) begin
                  odata    <= data_nx;
                  ouniform <= uni_nx;
                  state    <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_read_superpixel.sv
// tb/tb_read_superpixel.sv - scoreboard bench for read_superpixel
module tb_read_superpixel;

   localparam int LAT = 2;
`ifdef SPIXEL_UNIFORM_CHECK_EN
   localparam bit FULL = 1'b1;
   localparam int NRD  = 100;
`else
   localparam bit FULL = 1'b0;
   localparam int NRD  = 1;
`endif

   typedef struct {
      int         done_cyc;
      int         nrd;
      int         first;
      int         last;
      logic [7:0] data;
      logic       uni;
      logic       err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  x = '0;
   logic [5:0]  y = '0;
   logic        ireq_vld = 1'b0;
   logic        ordy;
   logic [7:0]  odata;
   logic        ouniform;
   logic        oerr;
   logic        odone;
   logic [18:0] oaddr;
   logic        orden;
   logic [7:0]  irdata;

   logic [7:0]  mem [0:307199];
   logic [7:0]  q1, q2;

   exp_t sb[$];
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;
   int   nrd_seen = 0;
   int   first_seen = 0;
   int   last_seen = 0;

   read_superpixel dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .ireq_vld(ireq_vld), .ordy(ordy),
      .odata(odata), .ouniform(ouniform), .oerr(oerr), .odone(odone),
      .oaddr(oaddr), .orden(orden), .irdata(irdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Two-cycle read RAM model.
   always @(posedge clk) begin
      if (orden) q1 <= mem[oaddr];
      q2 <= q1;
   end
   assign irdata = q2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total = total + 1;
      if (act === expv) passed = passed + 1;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                    name, act, act, expv, expv, cyc);
   endtask

   // Monitor: gathers the read stream and checks each result against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         nrd_seen = 0;
      end else begin
         if (orden) begin
            if (nrd_seen == 0) first_seen = int'(oaddr);
            last_seen = int'(oaddr);
            nrd_seen  = nrd_seen + 1;
         end
         if (odone) begin
            if (sb.size() == 0) begin
               chk("unexpected_odone", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("done_cycle", cyc + 1, e.done_cyc);
               chk("odata", odata, e.data);
               chk("ouniform", ouniform, e.uni);
               chk("oerr", oerr, e.err);
               chk("read_count", nrd_seen, e.nrd);
               if (e.nrd > 0) begin
                  chk("first_addr", first_seen, e.first);
                  chk("last_addr", last_seen, e.last);
               end
            end
            nrd_seen = 0;
         end
      end
   end

   // Drive one request; 'hold' keeps ireq_vld high for that many cycles.
   task automatic req(input int rx, input int ry, input int hold, input bit err,
                      input int first, input int last, input logic [7:0] data,
                      input logic uni);
      exp_t e;
      @(negedge clk);
      chk("ordy_before_req", ordy, 1'b1);
      x = rx[5:0];
      y = ry[5:0];
      ireq_vld = 1'b1;
      e.done_cyc = cyc + 1 + (err ? 1 : NRD + LAT + 1);
      e.nrd   = err ? 0 : NRD;
      e.first = first;
      e.last  = last;
      e.data  = err ? 8'h00 : data;
      e.uni   = err ? 1'b0 : uni;
      e.err   = err;
      sb.push_back(e);
      repeat (hold) @(negedge clk);
      ireq_vld = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || !ordy) && n < 400) begin
         @(negedge clk);
         n = n + 1;
      end
      if (n >= 400) chk("wait_idle_timeout", 32'd1, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 307200; i++) mem[i] = 8'h05;
      q1 = '0;
      q2 = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_ordy", ordy, 1'b1);
      chk("rst_orden", orden, 1'b0);
      chk("rst_oaddr", oaddr, 19'd0);
      chk("rst_odone", odone, 1'b0);
      chk("rst_odata", odata, 8'd0);
      chk("rst_ouniform", ouniform, 1'b0);
      chk("rst_oerr", oerr, 1'b0);
      rst_n = 1'b1;

      // Uniform block at the origin.
      req(0, 0, 1, 1'b0, 0, FULL ? 5769 : 0, 8'h05, 1'b1);
      wait_idle();
      // Bottom-right corner block: tlx=630, tly=470.
      req(63, 47, 1, 1'b0, 301430, FULL ? 307199 : 301430, 8'h05, 1'b1);
      wait_idle();
      // One odd pixel inside block (1,1).
      mem[17*640 + 15] = 8'h09;
      req(1, 1, 1, 1'b0, 6410, FULL ? 12179 : 6410, 8'h05, FULL ? 1'b0 : 1'b1);
      wait_idle();
      mem[17*640 + 15] = 8'h05;
      // Out-of-range rows.
      req(0, 48, 1, 1'b1, 0, 0, 8'h00, 1'b0);
      wait_idle();
      req(63, 63, 1, 1'b1, 0, 0, 8'h00, 1'b0);
      wait_idle();

      // Reset in the middle of a scan aborts it with no odone.
      req(0, 0, 1, 1'b0, 0, 0, 8'h05, 1'b1);
      repeat (FULL ? 50 : 2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ordy", ordy, 1'b1);
      chk("abort_orden", orden, 1'b0);
      chk("abort_oaddr", oaddr, 19'd0);
      chk("abort_odone", odone, 1'b0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_odata", odata, 8'd0);

      // Block (2,3) with a distinct top-left pixel.
      mem[30*640 + 20] = 8'h0C;
      req(2, 3, 1, 1'b0, 19220, FULL ? 24989 : 19220, 8'h0C, FULL ? 1'b0 : 1'b1);
      wait_idle();
      chk("hold_after_done_odata", odata, 8'h0C);

      // ireq_vld held while busy: exactly one accept.
      req(5, 5, 3, 1'b0, 32050, FULL ? 37819 : 32050, 8'h05, 1'b1);
      wait_idle();
      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
